// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control and ALU_Control.
// Optional feature macro: MULTICYCLE_BNE_EN (bne dispatch to BRANCH_NE).
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_BRANCH_NE = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MULTICYCLE_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
            OP_BNE:                               legal = BNE_EN;
            default:                              legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mcc_output_decode.sv
// Combinational state -> control word decode for the multicycle main control.
// With MULTICYCLE_BNE_EN undefined, BRANCH_NE never drives PCWriteCondNE.
module mcc_output_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    output ctrl_t      ctrl_o
);

    // Moore decode; only IllegalOp looks at the opcode, and only in DECODE.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b  = SRCB_IMM_SL2;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = ~op_is_legal(opcode_i);
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH, S_BRANCH_NE: begin
                ctrl_o.alu_src_a        = 1'b1;
                ctrl_o.alu_src_b        = SRCB_B;
                ctrl_o.alu_op           = ALUOP_SUB;
                ctrl_o.pc_write_cond    = (state_i == S_BRANCH);
                ctrl_o.pc_write_cond_ne = (state_i == S_BRANCH_NE) & BNE_EN;
                ctrl_o.pc_source        = PCSRC_ALUOUT;
                ctrl_o.instr_done       = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle MIPS datapath.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_main_control
    import multicycle_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               PCWriteCondNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               InstrDone,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_s;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_BNE:       state_d = BNE_EN ? S_BRANCH_NE : S_FETCH;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (Opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: state_d = S_MEM_WB;
            S_EXECUTE:  state_d = S_R_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_BRANCH_NE, S_JUMP:
                        state_d = S_FETCH;
            default:    state_d = S_IDLE;
        endcase
    end

    mcc_output_decode u_decode (
        .state_i  (state_q),
        .opcode_i (Opcode),
        .ctrl_o   (ctrl_s)
    );

    assign PCWrite       = ctrl_s.pc_write;
    assign PCWriteCond   = ctrl_s.pc_write_cond;
    assign PCWriteCondNE = ctrl_s.pc_write_cond_ne;
    assign IorD          = ctrl_s.i_or_d;
    assign MemRead       = ctrl_s.mem_read;
    assign MemWrite      = ctrl_s.mem_write;
    assign IRWrite       = ctrl_s.ir_write;
    assign MemtoReg      = ctrl_s.mem_to_reg;
    assign RegDst        = ctrl_s.reg_dst;
    assign RegWrite      = ctrl_s.reg_write;
    assign ALUSrcA       = ctrl_s.alu_src_a;
    assign ALUSrcB       = ctrl_s.alu_src_b;
    assign ALUOp         = ctrl_s.alu_op;
    assign PCSource      = ctrl_s.pc_source;
    assign InstrDone     = ctrl_s.instr_done;
    assign IllegalOp     = ctrl_s.illegal_op;
    assign State         = STATE_W'(state_q);

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
Moore-FSM main control unit for the multicycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives every datapath enable and mux select. Produces the 2-bit ALUOp consumed by the ALU_Control decoder: 00 = add, 01 = subtract, 10 = use funct field.

Parameters:
STATE_W, 4, width of state register and State debug port.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
Opcode  in  6  IR[31:26]; valid from DECODE onward
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU Zero=1 (beq)
PCWriteCondNE  out  1  PC load if ALU Zero=0 (bne; see optional feature)
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
MemtoReg  out  1  register write data select: 0=ALUOut, 1=MDR
RegDst  out  1  destination register select: 0=rt, 1=rd
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select: 0=PC, 1=A
ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
ALUOp  out  2  to ALU_Control
PCSource  out  2  PC source select: 00=ALU result, 01=ALUOut, 10=jump target
InstrDone  out  1  one-cycle pulse in final state of each instruction
IllegalOp  out  1  one-cycle pulse in DECODE for an unsupported opcode
State  out  STATE_W  current state (debug/verification)

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high. Any rising edge with rst=1 sets state to IDLE, including mid-instruction; the in-flight instruction is abandoned.
- Output derivation: all outputs are pure decodes of the state register (Moore), plus Opcode in DECODE for IllegalOp. No output depends on Opcode in any other state.
- Reset values: in IDLE every output is 0 and State=0. IDLE always goes to FETCH on the next edge with rst=0.
- Any output not listed for a state below is 0.
- States and encodings, with asserted outputs:
  - IDLE(0): all outputs 0.
  - FETCH(1): MemRead, IRWrite, ALUSrcB=01, ALUOp=00, PCWrite, PCSource=00.
  - DECODE(2): ALUSrcB=11, ALUOp=00.
  - MEM_ADDR(3): ALUSrcA, ALUSrcB=10, ALUOp=00.
  - MEM_READ(4): MemRead, IorD.
  - MEM_WB(5): RegWrite, MemtoReg, RegDst=0, InstrDone.
  - MEM_WRITE(6): MemWrite, IorD, InstrDone.
  - EXECUTE(7): ALUSrcA, ALUSrcB=00, ALUOp=10.
  - R_WB(8): RegWrite, RegDst, MemtoReg=0, InstrDone.
  - BRANCH(9): ALUSrcA, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, InstrDone.
  - JUMP(10): PCWrite, PCSource=10, InstrDone.
  - BRANCH_NE(11): as BRANCH, but PCWriteCondNE instead of PCWriteCond.
- Transitions:
  - FETCH -> DECODE.
  - DECODE dispatches on Opcode:
    - 000000 -> EXECUTE
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 000101 -> BRANCH_NE (only with the optional feature)
    - any other -> FETCH with IllegalOp=1 for that cycle; the instruction executes as a NOP (PC already advanced).
  - MEM_ADDR -> MEM_READ if Opcode=100011, else MEM_WRITE.
  - MEM_READ -> MEM_WB.
  - EXECUTE -> R_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, BRANCH_NE, JUMP -> FETCH.
  - Unused encodings (12-15) -> IDLE, outputs 0.
- Latency in cycles, FETCH to last state inclusive: lw 5, sw 4, R-type 4, beq/bne 3, j 3, illegal 2.
- At most one of PCWrite, PCWriteCond, PCWriteCondNE is 1 in any state.
- MemRead and MemWrite are never 1 together.

Optional Feature:
Macro MULTICYCLE_BNE_EN.
- Defined: opcode 000101 dispatches to BRANCH_NE; PCWriteCondNE is driven by the FSM.
- Undefined: 000101 is an illegal opcode (IllegalOp pulse, return to FETCH); BRANCH_NE is unreachable; PCWriteCondNE is tied to 0. The port list is unchanged in both builds.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - state encoding constants
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10), shared with ALU_Control
  - ALUSrcB and PCSource select constants
- One sub-module, mcc_output_decode: purely combinational state -> control word; the FSM keeps only the next-state logic and the state register.

Test Plan:
- Reset: hold rst 2 cycles, release -> State 0 with all outputs 0; next cycle FETCH with PCWrite=1, IRWrite=1, ALUSrcB=01.
- lw: Opcode=100011 -> states 1,2,3,4,5,1; MEM_READ has IorD=1, MemRead=1; MEM_WB has RegWrite=1, MemtoReg=1, InstrDone=1.
- sw then R-type:
  - sw (101011) -> 1,2,3,6 with MemWrite=1.
  - R-type (000000) -> 1,2,7,8; EXECUTE has ALUOp=10; R_WB has RegDst=1, RegWrite=1.
- beq and j:
  - beq (000100) -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01.
  - j (000010) -> JUMP with PCWrite=1, PCSource=10.
- Illegal/bne: Opcode=001000 -> IllegalOp=1 in DECODE, then FETCH. Opcode=000101 -> BRANCH_NE with PCWriteCondNE=1 when MULTICYCLE_BNE_EN is defined; IllegalOp=1 when it is not.
- Reset mid-operation: assert rst during MEM_READ of lw -> next edge State=0; MEM_WB never occurs and RegWrite stays 0.
